// File: rtl/commit_monitor_pkg.sv
// Shared types for the retire-stage commit monitor: halt causes, FSM states
// and the trace record carried through the trace FIFO.
package commit_monitor_pkg;

  typedef enum logic [1:0] {
    HALT_NONE    = 2'd0,
    HALT_END     = 2'd1,
    HALT_LOOP    = 2'd2,
    HALT_TIMEOUT = 2'd3
  } halt_cause_e;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_e;

  // jal x0,0 -- the canonical self-loop used by test programs to park the core
  localparam logic [31:0] LOOP_INSTR = 32'h0000006f;

  // Record fields are sized for the widest supported XLEN/CNT_W; narrower
  // instances zero-extend into them and the constant upper bits trim away.
  localparam int MAX_SEQ_W = 64;
  localparam int MAX_PC_W  = 64;

  typedef struct packed {
    logic [MAX_SEQ_W-1:0] seq;
    logic [MAX_PC_W-1:0]  pc;
    logic [31:0]          instr;
  } trace_entry_t;

endpackage

// File: rtl/trace_fifo.sv
// First-word-fall-through FIFO holding retire trace records; the head entry
// is presented combinationally while the FIFO is not empty.
module trace_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  input  logic             pop,
  output logic             empty,
  output logic [WIDTH-1:0] head_data
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full      = (count_q == (AW+1)'(DEPTH));
  assign empty     = (count_q == '0);
  assign head_data = mem_q[rd_ptr_q];

  // A push into a full FIFO is still accepted when the head leaves the same cycle.
  always_comb begin
    do_push  = push && (!full || pop);
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push && !do_pop)      count_d = count_q + (AW+1)'(1);
    else if (do_pop && !do_push) count_d = count_q - (AW+1)'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/commit_monitor.sv
// Retire-stage run monitor: counts cycles and retirements, detects end-PC,
// self-loop and timeout halts, and buffers a retire trace for draining.
module commit_monitor
  import commit_monitor_pkg::*;
#(
  parameter int               XLEN        = 32,
  parameter logic [XLEN-1:0]  HALT_PC     = 32'h000000ff,
  parameter int               TIMEOUT     = 100000,
  parameter int               LOOP_LIMIT  = 4,
  parameter int               TRACE_DEPTH = 16,
  parameter int               CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             ret_valid,
  input  logic [XLEN-1:0]  ret_pc,
  input  logic [31:0]      ret_instr,
  output logic             trace_valid,
  input  logic             trace_ready,
  output logic [CNT_W-1:0] trace_seq,
  output logic [XLEN-1:0]  trace_pc,
  output logic [31:0]      trace_instr,
  output logic             trace_overflow,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt,
  output logic             halted,
  output logic [1:0]       halt_cause
);

  localparam int LW = $clog2(LOOP_LIMIT + 1);

  state_e           state_q, state_d;
  halt_cause_e      cause_q, cause_d;
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic [LW-1:0]    loop_q, loop_d;
  logic             overflow_q, overflow_d;

  logic             run, retire, is_loop, end_hit, loop_hit, timeout_hit;
  logic [LW-1:0]    loop_inc;
  logic             fifo_full, fifo_empty, pop_fire;
  trace_entry_t     push_entry, head_entry;

  assign run      = (state_q == ST_RUN);
  assign retire   = run && ret_valid;
  assign is_loop  = (ret_instr == LOOP_INSTR);
  assign loop_inc = loop_q + LW'(1);
  assign pop_fire = trace_ready && !fifo_empty;

  always_comb begin
    end_hit     = retire && (ret_pc == HALT_PC);
    loop_hit    = retire && is_loop && (loop_inc == LW'(LOOP_LIMIT));
    timeout_hit = run && (cycle_q == CNT_W'(TIMEOUT - 1));

    state_d    = state_q;
    cause_d    = cause_q;
    cycle_d    = cycle_q;
    instret_d  = instret_q;
    loop_d     = loop_q;
    overflow_d = overflow_q;

    if (run) begin
      if (cycle_q != '1) cycle_d = cycle_q + CNT_W'(1);
      if (end_hit || loop_hit || timeout_hit) state_d = ST_HALTED;
      if (end_hit)          cause_d = HALT_END;
      else if (loop_hit)    cause_d = HALT_LOOP;
      else if (timeout_hit) cause_d = HALT_TIMEOUT;
    end

    if (retire) begin
      if (instret_q != '1) instret_d = instret_q + CNT_W'(1);
      loop_d = is_loop ? loop_inc : '0;
      if (fifo_full && !pop_fire) overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state_q    <= ST_RUN;
      cause_q    <= HALT_NONE;
      cycle_q    <= '0;
      instret_q  <= '0;
      loop_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cause_q    <= cause_d;
      cycle_q    <= cycle_d;
      instret_q  <= instret_d;
      loop_q     <= loop_d;
      overflow_q <= overflow_d;
    end
  end

  always_comb begin
    push_entry       = '0;
    push_entry.seq   = MAX_SEQ_W'(instret_q);
    push_entry.pc    = MAX_PC_W'(ret_pc);
    push_entry.instr = ret_instr;
  end

  trace_fifo #(
    .DEPTH (TRACE_DEPTH),
    .WIDTH ($bits(trace_entry_t))
  ) u_trace_fifo (
    .clk       (clk),
    .rst       (rstn),
    .push      (retire),
    .push_data (push_entry),
    .full      (fifo_full),
    .pop       (pop_fire),
    .empty     (fifo_empty),
    .head_data (head_entry)
  );

  assign trace_valid    = !fifo_empty;
  assign trace_seq      = CNT_W'(head_entry.seq);
  assign trace_pc       = XLEN'(head_entry.pc);
  assign trace_instr    = head_entry.instr;
  assign trace_overflow = overflow_q;
  assign cycle_cnt      = cycle_q;
  assign instret_cnt    = instret_q;
  assign halted         = (state_q == ST_HALTED);
  assign halt_cause     = cause_q;

endmodule

// File: tb/tb_commit_monitor.sv
// Directed bench for commit_monitor: trace ordering, the three halt causes,
// FIFO full/overflow behaviour and asynchronous reset while halted.
module tb_commit_monitor;

  logic        clk;
  logic        rstn;
  logic        ret_valid;
  logic [31:0] ret_pc;
  logic [31:0] ret_instr;
  logic        trace_valid;
  logic        trace_ready;
  logic [31:0] trace_seq;
  logic [31:0] trace_pc;
  logic [31:0] trace_instr;
  logic        trace_overflow;
  logic [31:0] cycle_cnt;
  logic [31:0] instret_cnt;
  logic        halted;
  logic [1:0]  halt_cause;

  int checkCount = 0;
  int failCount  = 0;

  localparam logic [31:0] NOP  = 32'h00000013;
  localparam logic [31:0] LOOP = 32'h0000006f;

  commit_monitor #(
    .XLEN        (32),
    .HALT_PC     (32'h000000ff),
    .TIMEOUT     (20),
    .LOOP_LIMIT  (4),
    .TRACE_DEPTH (4),
    .CNT_W       (32)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .ret_valid      (ret_valid),
    .ret_pc         (ret_pc),
    .ret_instr      (ret_instr),
    .trace_valid    (trace_valid),
    .trace_ready    (trace_ready),
    .trace_seq      (trace_seq),
    .trace_pc       (trace_pc),
    .trace_instr    (trace_instr),
    .trace_overflow (trace_overflow),
    .cycle_cnt      (cycle_cnt),
    .instret_cnt    (instret_cnt),
    .halted         (halted),
    .halt_cause     (halt_cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checkCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Presents one cycle of inputs, then returns 1 time unit after the edge.
  task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                               input logic rdy);
    ret_valid   = v;
    ret_pc      = pc;
    ret_instr   = instr;
    trace_ready = rdy;
    @(posedge clk);
    #1;
    ret_valid = 1'b0;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 32'h0, NOP, rdy);
  endtask

  task automatic resetDut();
    ret_valid   = 1'b0;
    ret_pc      = '0;
    ret_instr   = NOP;
    trace_ready = 1'b0;
    rstn        = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rstn = 1'b0;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, ".halted"},   64'(halted), 64'd0);
    checkOutput({tag, ".cause"},    64'(halt_cause), 64'd0);
    checkOutput({tag, ".tvalid"},   64'(trace_valid), 64'd0);
    checkOutput({tag, ".overflow"}, 64'(trace_overflow), 64'd0);
    checkOutput({tag, ".cycle"},    64'(cycle_cnt), 64'd0);
    checkOutput({tag, ".instret"},  64'(instret_cnt), 64'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired got=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rstn = 1'b1;
    #1;
    checkResetState("rst_async");
    resetDut();
    checkResetState("rst_release");

    // Five straight-line retires, drained as they arrive.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 32'(4 * i), NOP, 1'b1);
      checkOutput($sformatf("seq_%0d", i), 64'(trace_seq), 64'(i));
      checkOutput($sformatf("pc_%0d", i), 64'(trace_pc), 64'(4 * i));
    end
    checkOutput("five.instret", 64'(instret_cnt), 64'd5);
    checkOutput("five.halted", 64'(halted), 64'd0);
    idle(1, 1'b1);
    checkOutput("five.drained", 64'(trace_valid), 64'd0);

    // END halt sampled at cycle_cnt == 9.
    resetDut();
    idle(9, 1'b1);
    checkOutput("end.cycle_before", 64'(cycle_cnt), 64'd9);
    applyStimulus(1'b1, 32'h000000ff, NOP, 1'b1);
    checkOutput("end.halted", 64'(halted), 64'd1);
    checkOutput("end.cause", 64'(halt_cause), 64'd1);
    checkOutput("end.instret", 64'(instret_cnt), 64'd1);
    checkOutput("end.cycle", 64'(cycle_cnt), 64'd10);
    checkOutput("end.tvalid", 64'(trace_valid), 64'd1);
    checkOutput("end.tpc", 64'(trace_pc), 64'h000000ff);
    checkOutput("end.tseq", 64'(trace_seq), 64'd0);
    applyStimulus(1'b1, 32'h00000008, NOP, 1'b1);
    applyStimulus(1'b1, 32'h0000000c, NOP, 1'b1);
    checkOutput("end.frozen_instret", 64'(instret_cnt), 64'd1);
    checkOutput("end.frozen_cycle", 64'(cycle_cnt), 64'd10);
    checkOutput("end.frozen_cause", 64'(halt_cause), 64'd1);
    checkOutput("end.no_push", 64'(trace_valid), 64'd0);

    // Self-loop: a non-loop retire restarts the run of four.
    resetDut();
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'h40, LOOP, 1'b1);
    checkOutput("loop.after3", 64'(halted), 64'd0);
    applyStimulus(1'b1, 32'h40, NOP, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'h44, LOOP, 1'b1);
    checkOutput("loop.after_nop3", 64'(halted), 64'd0);
    applyStimulus(1'b1, 32'h44, LOOP, 1'b1);
    checkOutput("loop.halted", 64'(halted), 64'd1);
    checkOutput("loop.cause", 64'(halt_cause), 64'd2);
    checkOutput("loop.instret", 64'(instret_cnt), 64'd8);
    checkOutput("loop.cycle", 64'(cycle_cnt), 64'd8);

    // Timeout on the 20th edge.
    resetDut();
    idle(19, 1'b1);
    checkOutput("to.pre_halted", 64'(halted), 64'd0);
    checkOutput("to.pre_cycle", 64'(cycle_cnt), 64'd19);
    idle(1, 1'b1);
    checkOutput("to.halted", 64'(halted), 64'd1);
    checkOutput("to.cause", 64'(halt_cause), 64'd3);
    checkOutput("to.cycle", 64'(cycle_cnt), 64'd20);
    idle(2, 1'b1);
    checkOutput("to.frozen_cycle", 64'(cycle_cnt), 64'd20);

    // END beats TIMEOUT on the same edge.
    resetDut();
    idle(19, 1'b1);
    applyStimulus(1'b1, 32'h000000ff, NOP, 1'b1);
    checkOutput("prio.cause", 64'(halt_cause), 64'd1);
    checkOutput("prio.cycle", 64'(cycle_cnt), 64'd20);
    checkOutput("prio.instret", 64'(instret_cnt), 64'd1);

    // Full FIFO with simultaneous pop and push keeps the new entry.
    resetDut();
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'(32'h200 + 4 * i), NOP, 1'b0);
    checkOutput("full.overflow", 64'(trace_overflow), 64'd0);
    checkOutput("full.head_pc", 64'(trace_pc), 64'h200);
    applyStimulus(1'b1, 32'h300, 32'h00100093, 1'b1);
    checkOutput("swap.overflow", 64'(trace_overflow), 64'd0);
    checkOutput("swap.head_seq", 64'(trace_seq), 64'd1);
    idle(1, 1'b1);
    checkOutput("swap.seq2", 64'(trace_seq), 64'd2);
    idle(1, 1'b1);
    checkOutput("swap.seq3", 64'(trace_seq), 64'd3);
    idle(1, 1'b1);
    checkOutput("swap.seq4", 64'(trace_seq), 64'd4);
    checkOutput("swap.pc4", 64'(trace_pc), 64'h300);
    checkOutput("swap.instr4", 64'(trace_instr), 64'h00100093);
    idle(1, 1'b1);
    checkOutput("swap.empty", 64'(trace_valid), 64'd0);

    // Six retires into a stalled depth-4 FIFO drop two.
    resetDut();
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'(32'h200 + 4 * i), NOP, 1'b0);
    checkOutput("ovf.after4", 64'(trace_overflow), 64'd0);
    for (int i = 4; i < 6; i++) applyStimulus(1'b1, 32'(32'h200 + 4 * i), NOP, 1'b0);
    checkOutput("ovf.sticky", 64'(trace_overflow), 64'd1);
    checkOutput("ovf.instret", 64'(instret_cnt), 64'd6);
    checkOutput("ovf.head_seq", 64'(trace_seq), 64'd0);
    idle(3, 1'b1);
    checkOutput("ovf.last_seq", 64'(trace_seq), 64'd3);
    checkOutput("ovf.last_pc", 64'(trace_pc), 64'h20c);
    idle(1, 1'b1);
    checkOutput("ovf.empty", 64'(trace_valid), 64'd0);

    // Reset while halted with entries queued.
    resetDut();
    applyStimulus(1'b1, 32'h0, NOP, 1'b0);
    applyStimulus(1'b1, 32'h4, NOP, 1'b0);
    applyStimulus(1'b1, 32'hff, NOP, 1'b0);
    checkOutput("rh.halted", 64'(halted), 64'd1);
    checkOutput("rh.queued", 64'(trace_valid), 64'd1);
    #2;
    rstn = 1'b1;
    #1;
    checkResetState("rh.async");
    @(posedge clk);
    #1;
    rstn = 1'b0;
    applyStimulus(1'b1, 32'h0, NOP, 1'b0);
    checkOutput("rh.tvalid", 64'(trace_valid), 64'd1);
    checkOutput("rh.seq", 64'(trace_seq), 64'd0);
    checkOutput("rh.pc", 64'(trace_pc), 64'd0);
    checkOutput("rh.instret", 64'(instret_cnt), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
